// File: rtl/gray_conv_pkg.sv
// Shared types and constants for the round-robin Gray/binary conversion arbiter.
package gray_conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RESP
  } state_t;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

endpackage

// File: rtl/bin2grayConverter.sv
// Combinational binary to reflected-Gray converter.
module bin2grayConverter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray2binConverter.sv
// Combinational reflected-Gray to binary converter (MSB-first xor chain).
module gray2binConverter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] gray_i,
  output logic [N-1:0] bin_o
);

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b        = '0;
    b[N-1]   = g[N-1];
    for (int i = int'(N) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign bin_o = g2b(gray_i);

endmodule

// File: rtl/gray_conv_unit.sv
// Shared combinational conversion unit: one converter of each kind, output picked by mode.
module gray_conv_unit
  import gray_conv_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         mode,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  logic [N-1:0] gray_w;
  logic [N-1:0] bin_w;

  bin2grayConverter #(.N(N)) u_b2g (
    .bin_i  (din),
    .gray_o (gray_w)
  );

  gray2binConverter #(.N(N)) u_g2b (
    .gray_i (din),
    .bin_o  (bin_w)
  );

  assign dout = (mode == MODE_G2B) ? bin_w : gray_w;

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one registered Gray/binary conversion unit among M requesters.
// Each transaction is IDLE (grant) -> CONV (register result) -> RESP (hold until consumed).
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned M    = 4,
  localparam int unsigned IW  = (M > 1) ? $clog2(M) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M-1:0]   req_valid,
  input  logic [M-1:0]   req_mode,
  input  logic [M*N-1:0] req_data,
  output logic [M-1:0]   req_ready,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_data,
  output logic [IW-1:0]  rsp_id,
  output logic           rsp_mode,
  output logic           busy
);

  // Returns {found, winner}, searching ptr, ptr+1, ..., M-1, 0, ...
  function automatic logic [IW:0] rr_pick(input logic [M-1:0] valid, input logic [IW-1:0] ptr);
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] idx_l;
    int            idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < int'(M); i++) begin
      idx = int'(ptr) + i;
      if (idx >= int'(M)) idx -= int'(M);
      idx_l = IW'(idx);
      if (!found && valid[idx_l]) begin
        found = 1'b1;
        win   = idx_l;
      end
    end
    return {found, win};
  endfunction

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  op_data_q, op_data_d;
  logic          op_mode_q, op_mode_d;
  logic [IW-1:0] op_id_q, op_id_d;
  logic [N-1:0]  rsp_data_q, rsp_data_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic          rsp_mode_q, rsp_mode_d;

  logic          found;
  logic [IW-1:0] win;
  logic          grant;
  logic          accept;
  logic [N-1:0]  conv_dout;

  always_comb begin
    {found, win} = rr_pick(req_valid, ptr_q);
  end

  // Gated by rst so no grant is visible while reset is held.
  assign grant  = (state_q == IDLE) && found && !rst;
  assign accept = grant && req_valid[win];

  gray_conv_unit #(.N(N)) u_unit (
    .mode (op_mode_q),
    .din  (op_data_q),
    .dout (conv_dout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CONV;
      CONV:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
    rsp_mode  = rsp_mode_q;
  end

  // Operand capture, pointer advance and result registration
  always_comb begin
    ptr_d      = ptr_q;
    op_data_d  = op_data_q;
    op_mode_d  = op_mode_q;
    op_id_d    = op_id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rsp_mode_d = rsp_mode_q;
    if (accept) begin
      op_data_d = req_data[win*N +: N];
      op_mode_d = req_mode[win];
      op_id_d   = win;
      ptr_d     = (win == IW'(M - 1)) ? '0 : win + 1'b1;
    end
    if (state_q == CONV) begin
      rsp_data_d = conv_dout;
      rsp_id_d   = op_id_q;
      rsp_mode_d = op_mode_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      op_data_q  <= '0;
      op_mode_q  <= MODE_B2G;
      op_id_q    <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_mode_q <= MODE_B2G;
    end else begin
      ptr_q      <= ptr_d;
      op_data_q  <= op_data_d;
      op_mode_q  <= op_mode_d;
      op_id_q    <= op_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rsp_mode_q <= rsp_mode_d;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter (N=4, M=4) with a response scoreboard queue.
module tb_gray_conv_arbiter;
  import gray_conv_pkg::*;

  localparam int N  = 4;
  localparam int M  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [M-1:0]   req_valid;
  logic [M-1:0]   req_mode;
  logic [M*N-1:0] req_data;
  logic [M-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;
  logic           rsp_mode;
  logic           busy;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [IW-1:0] id;
    logic          mode;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  gray_conv_arbiter #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_mode  (rsp_mode),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: Gray->binary via prefix parity, b[i] = ^(g >> i).
  function automatic logic [N-1:0] model_conv(input logic mode, input logic [N-1:0] d);
    logic [N-1:0] r;
    logic [N-1:0] s;
    if (mode == MODE_B2G) begin
      r = d ^ (d >> 1);
    end else begin
      for (int i = 0; i < N; i++) begin
        s    = d >> i;
        r[i] = ^s;
      end
    end
    return r;
  endfunction

  function automatic logic [M-1:0] onehot(input int k);
    logic [M-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input logic mode, input logic [N-1:0] data);
    exp_t e;
    e.data = model_conv(mode, data);
    e.id   = IW'(k);
    e.mode = mode;
    sb.push_back(e);
  endtask

  // Full single transaction for requester k with rsp_ready held high.
  task automatic do_txn(input int k, input logic mode, input logic [N-1:0] data,
                        output logic [N-1:0] got);
    int   n;
    exp_t e;
    got = '0;
    req_valid[k]         = 1'b1;
    req_mode[k]          = mode;
    req_data[k*N +: N]   = data;
    #1;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== onehot(k)) begin
      errors++;
      $display("FAIL txn_grant k=%0d: req_ready=%b expected %b", k, req_ready, onehot(k));
    end
    if (req_ready[k] !== 1'b1) begin
      req_valid[k] = 1'b0;
      return;
    end
    push_exp(k, mode, data);
    tick();
    req_valid[k] = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL txn_conv_cycle k=%0d: rsp_valid=%b busy=%b expected 0/1", k, rsp_valid, busy);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL txn_latency k=%0d: rsp_valid=%b expected 1", k, rsp_valid);
    end
    e = sb.pop_front();
    checks++;
    if (rsp_data !== e.data || rsp_id !== e.id || rsp_mode !== e.mode) begin
      errors++;
      $display("FAIL txn_rsp k=%0d: data=%b id=%0d mode=%b expected data=%b id=%0d mode=%b",
               k, rsp_data, rsp_id, rsp_mode, e.data, e.id, e.mode);
    end
    got = rsp_data;
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL txn_return_idle k=%0d: busy=%b rsp_valid=%b expected 0/0", k, busy, rsp_valid);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = '1;
    req_mode  = '0;
    req_data  = 16'h1234;
    rsp_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_busy: rsp_valid=%b busy=%b expected 0/0", rsp_valid, busy);
    end
    checks++;
    if (rsp_data !== '0 || rsp_id !== '0 || rsp_mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: data=%b id=%0d mode=%b expected 0/0/0", rsp_data, rsp_id, rsp_mode);
    end
    req_valid = '0;
    rst       = 1'b0;
    tick();
  endtask

  task automatic test_single;
    logic [N-1:0] got;
    do_txn(0, MODE_B2G, 4'b1011, got);
    checks++;
    if (got !== 4'b1110) begin
      errors++;
      $display("FAIL single_b2g: got %b expected 1110", got);
    end
    do_txn(2, MODE_G2B, 4'b1110, got);
    checks++;
    if (got !== 4'b1011) begin
      errors++;
      $display("FAIL single_g2b: got %b expected 1011", got);
    end
  endtask

  task automatic test_round_robin;
    int   k;
    int   n;
    exp_t e;
    rst = 1'b1;
    for (int i = 0; i < M; i++) begin
      req_data[i*N +: N] = N'((i * 5 + 3) % 16);
      req_mode[i]        = i[0];
    end
    req_valid = '1;
    tick();
    checks++;
    if (req_ready !== '0) begin
      errors++;
      $display("FAIL rr_ready_in_reset: got %b expected 0000", req_ready);
    end
    rst = 1'b0;
    #1;
    for (int j = 0; j < 5; j++) begin
      k = j % M;
      n = 0;
      while (busy !== 1'b0 && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (req_ready !== onehot(k)) begin
        errors++;
        $display("FAIL rr_grant j=%0d: req_ready=%b expected %b", j, req_ready, onehot(k));
      end
      push_exp(k, req_mode[k], req_data[k*N +: N]);
      tick();
      checks++;
      if (!$onehot0(req_ready) || req_ready !== '0) begin
        errors++;
        $display("FAIL rr_ready_conv j=%0d: req_ready=%b expected 0000", j, req_ready);
      end
      tick();
      e = sb.pop_front();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id || rsp_mode !== e.mode) begin
        errors++;
        $display("FAIL rr_rsp j=%0d: v=%b data=%b id=%0d mode=%b expected v=1 data=%b id=%0d mode=%b",
                 j, rsp_valid, rsp_data, rsp_id, rsp_mode, e.data, e.id, e.mode);
      end
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  // Pointer is at 1 here (last grant was requester 0).
  task automatic test_backpressure;
    int   n;
    exp_t e;
    rsp_ready          = 1'b0;
    req_valid[1]       = 1'b1;
    req_mode[1]        = MODE_G2B;
    req_data[1*N +: N] = 4'b0110;
    #1;
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant: req_ready=%b expected 0010", req_ready);
    end
    push_exp(1, MODE_G2B, 4'b0110);
    tick();
    req_valid[1] = 1'b0;
    req_valid[3] = 1'b1;
    tick();
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== '0 ||
          rsp_data !== e.data || rsp_id !== e.id || rsp_mode !== e.mode) begin
        errors++;
        $display("FAIL bp_hold c=%0d: v=%b busy=%b rdy=%b data=%b id=%0d expected 1/1/0000/%b/%0d",
                 c, rsp_valid, busy, req_ready, rsp_data, rsp_id, e.data, e.id);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_release: busy=%b v=%b rdy=%b expected 0/0/1000", busy, rsp_valid, req_ready);
    end
    req_valid[3] = 1'b0;
    tick();
  endtask

  // Pointer is at 2 here; the aborted grant of requester 2 moves it to 3 unless reset clears it.
  task automatic test_reset_mid;
    int n;
    req_valid[2]       = 1'b1;
    req_mode[2]        = MODE_B2G;
    req_data[2*N +: N] = 4'b0101;
    #1;
    n = 0;
    while (req_ready[2] !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rm_grant: req_ready=%b expected 0100", req_ready);
    end
    tick();
    req_valid[2] = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rm_in_conv: busy=%b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || rsp_data !== '0) begin
      errors++;
      $display("FAIL rm_async: v=%b busy=%b rdy=%b data=%b expected 0/0/0000/0000",
               rsp_valid, busy, req_ready, rsp_data);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rm_stale c=%0d: v=%b busy=%b expected 0/0", c, rsp_valid, busy);
      end
    end
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rm_ptr_cleared: req_ready=%b expected 0001", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_roundtrip;
    logic [N-1:0] g;
    logic [N-1:0] b;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      do_txn(0, MODE_B2G, N'(i), g);
      do_txn(1, MODE_G2B, g, b);
      checks++;
      if (b !== N'(i)) begin
        errors++;
        $display("FAIL roundtrip i=%0d: got %b expected %b", i, b, N'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_roundtrip();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
